// File: rtl/backprop_pkg.sv
// Shared types and helpers for the backprop-stack systolic array sequencer.
package backprop_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam int LAYER_SIZE_W = 8;
  localparam int MAX_LANES    = 32;

  // Bit i is set when lane i of the tile starting at neuron 'base' holds a real neuron.
  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [31:0] base,
                                                     input logic [31:0] n);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      m[i] = (base + 32'(i)) < n;
    end
    return m;
  endfunction

endpackage

// File: rtl/onehot_lane_counter.sv
// Mod-size lane counter producing a registered one-hot lane select.
module onehot_lane_counter #(
  parameter int size = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            hold,
  input  logic            clear,
  input  logic            en,
  output logic [size-1:0] one_hot
);

  localparam logic [size-1:0] LANE0 = size'(1);

  logic [size-1:0] lane_q, lane_d;
  logic [size-1:0] oh_q, oh_d;

  // lane_q is the lane the next enabled cycle will select.
  always_comb begin
    lane_d = lane_q;
    oh_d   = oh_q;
    if (!hold) begin
      if (clear) begin
        lane_d = LANE0;
        oh_d   = '0;
      end else if (en) begin
        oh_d   = lane_q;
        lane_d = (lane_q << 1) | (lane_q >> (size - 1));
      end else begin
        oh_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q <= LANE0;
      oh_q   <= '0;
    end else begin
      lane_q <= lane_d;
      oh_q   <= oh_d;
    end
  end

  assign one_hot = oh_q;

endmodule

// File: rtl/systolic_array_controller.sv
// Walks layers top-down, tiling neurons across the array lanes; streams the
// fan-out index per tile and drains the pipeline. All outputs are registered.
module systolic_array_controller
  import backprop_pkg::*;
#(
  parameter int data_size      = 16,
  parameter int max_layer_size = 5,
  parameter int size           = 3
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start,
  input  logic                                   hold,
  input  logic [7:0]                             num_layers,
  input  logic [LAYER_SIZE_W*max_layer_size-1:0] layer_sizes,
  output logic                                   reset_counter_in,
  output logic [31:0]                            address,
  output logic [31:0]                            current_layer,
  output logic [size-1:0]                        one_address,
  output logic [size-1:0]                        output_replace_pattern,
  output logic                                   busy,
  output logic                                   done
);

  localparam int          TBL_W     = LAYER_SIZE_W * max_layer_size;
  localparam logic [31:0] SIZE32    = 32'(size);
  localparam logic [31:0] LAST_LANE = 32'(size - 1);

  if (size < 1 || size > MAX_LANES || data_size < 1 || max_layer_size < 2) begin : g_bad_params
    $error("systolic_array_controller: unsupported parameter set");
  end

  // Neuron count of a layer; zero entries and indices past the table read as 1.
  function automatic logic [31:0] n_at(input logic [31:0] idx, input logic [TBL_W-1:0] tbl);
    logic [31:0] n;
    n = 32'd1;
    for (int i = 0; i < max_layer_size; i++) begin
      if (idx == 32'(i) && tbl[LAYER_SIZE_W*i +: LAYER_SIZE_W] != '0) begin
        n = 32'(tbl[LAYER_SIZE_W*i +: LAYER_SIZE_W]);
      end
    end
    return n;
  endfunction

  state_t            state_q, state_d;
  logic [TBL_W-1:0]  sizes_q, sizes_d;
  logic [31:0]       layer_q, layer_d;
  logic [31:0]       base_q, base_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       drain_q, drain_d;
  logic              rci_q, rci_d;
  logic [size-1:0]   mask_q, mask_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [31:0]       n_cur, k_cur, nl_eff;
  logic [size-1:0]   tile_mask;

  assign n_cur     = n_at(layer_q, sizes_q);
  assign k_cur     = n_at(layer_q + 32'd1, sizes_q);
  assign nl_eff    = (32'(num_layers) > 32'(max_layer_size)) ? 32'(max_layer_size)
                                                             : 32'(num_layers);
  assign tile_mask = size'(lane_mask(base_q, n_cur));

  always_comb begin
    state_d = state_q;
    sizes_d = sizes_q;
    layer_d = layer_q;
    base_d  = base_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    rci_d   = rci_q;
    mask_d  = mask_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (!hold) begin
      rci_d  = 1'b0;
      done_d = 1'b0;
      mask_d = '0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sizes_d = layer_sizes;
            if (num_layers >= 8'd2) begin
              state_d = LOAD;
              layer_d = nl_eff - 32'd2;
              base_d  = '0;
              addr_d  = '0;
              rci_d   = 1'b1;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        LOAD: begin
          state_d = STREAM;
        end
        STREAM: begin
          if (addr_q == k_cur - 32'd1) begin
            state_d = DRAIN;
            drain_d = '0;
            if (LAST_LANE == 32'd0) mask_d = tile_mask;
          end else begin
            addr_d = addr_q + 32'd1;
          end
        end
        DRAIN: begin
          if (drain_q == LAST_LANE) begin
            if (base_q + SIZE32 < n_cur) begin
              state_d = LOAD;
              base_d  = base_q + SIZE32;
              addr_d  = '0;
              rci_d   = 1'b1;
            end else if (layer_q != 32'd0) begin
              state_d = LOAD;
              layer_d = layer_q - 32'd1;
              base_d  = '0;
              addr_d  = '0;
              rci_d   = 1'b1;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            drain_d = drain_q + 32'd1;
            if (drain_q + 32'd1 == LAST_LANE) mask_d = tile_mask;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
      busy_d = (state_d != IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sizes_q <= '0;
      layer_q <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      drain_q <= '0;
      rci_q   <= 1'b0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sizes_q <= sizes_d;
      layer_q <= layer_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      rci_q   <= rci_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  onehot_lane_counter #(.size(size)) u_lane (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (hold),
    .clear   (state_d != STREAM),
    .en      (state_d == STREAM),
    .one_hot (one_address)
  );

  assign reset_counter_in       = rci_q;
  assign address                = addr_q;
  assign current_layer          = layer_q;
  assign output_replace_pattern = mask_q;
  assign busy                   = busy_q;
  assign done                   = done_q;

endmodule
